// File: rtl/sd_pkg.sv
// Shared SD link definitions: frame geometry, CRC7 polynomial, fixed frame bits
// and the command-path FSM encoding used by both transmit and receive sides.
package sd_pkg;

  localparam int FRAME_WIDTH = 48;
  localparam int CRC_WIDTH   = 7;

  localparam logic [CRC_WIDTH-1:0] CRC7_POLY = 7'h09;

  localparam logic START_BIT   = 1'b0;
  localparam logic TX_BIT_HOST = 1'b1;
  localparam logic END_BIT     = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BODY = 3'd1,
    CRC  = 3'd2,
    ENDB = 3'd3,
    DONE = 3'd4
  } sdState_t;

  // One serial step of x^7+x^3+1, MSB-first.
  function automatic logic [CRC_WIDTH-1:0] crc7Next(input logic [CRC_WIDTH-1:0] crc,
                                                    input logic dataBit);
    logic feedback;
    feedback = dataBit ^ crc[CRC_WIDTH-1];
    return {crc[CRC_WIDTH-2:0], 1'b0} ^ (feedback ? CRC7_POLY : '0);
  endfunction

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 accumulator. Clear restarts from zero; when clear and advance
// coincide the presented bit is folded into the fresh remainder.
module crc7_serial
  import sd_pkg::*;
(
  input  logic                 iClock_SD,
  input  logic                 iReset,
  input  logic                 iClear,
  input  logic                 iAdvance,
  input  logic                 iData,
  output logic [CRC_WIDTH-1:0] oCrc
);

  always_ff @(posedge iClock_SD or negedge iReset) begin
    if (!iReset) begin
      oCrc <= '0;
    end else if (iClear) begin
      oCrc <= iAdvance ? crc7Next('0, iData) : '0;
    end else if (iAdvance) begin
      oCrc <= crc7Next(oCrc, iData);
    end
  end

endmodule

// File: rtl/sd_cmd_serializer.sv
// SD CMD-line framer: builds start/tx/index/argument/CRC7/end, shifts MSB-first,
// one bit per enabled clock; iEnable low freezes everything.
module sd_cmd_serializer
  import sd_pkg::*;
(
  input  logic                   iClock_SD,
  input  logic                   iReset,
  input  logic                   iEnable,
  input  logic                   iStart,
  input  logic [5:0]             iIndex,
  input  logic [31:0]            iArgument,
  output logic                   oSerial,
  output logic                   oOutputEnable,
  output logic                   oBusy,
  output logic                   oComplete,
  output logic [FRAME_WIDTH-1:0] oFrame
);

  sdState_t               state;
  logic [5:0]             bitCount;     // frame bit index currently on the line
  logic [38:0]            bodyShift;    // bits 46..8 still to be launched
  logic [FRAME_WIDTH-1:0] txAccum;      // everything launched so far
  logic [CRC_WIDTH-1:0]   crc;
  logic                   crcClear;
  logic                   crcAdvance;
  logic                   crcData;
  logic                   acceptNow;
  logic                   nextBit;
  logic [2:0]             crcIdx;

  // DONE with its pulse already shown counts as the return to IDLE, so a held
  // iStart is taken on that same edge and frames repeat every 49 cycles.
  assign acceptNow = iEnable && iStart &&
                     ((state == IDLE) || ((state == DONE) && oComplete));

  assign crcIdx = bitCount[2:0] - 3'd2;

  always_comb begin
    nextBit = END_BIT;
    case (state)
      BODY:    nextBit = (bitCount == 6'd8) ? crc[CRC_WIDTH-1] : bodyShift[38];
      CRC:     nextBit = (bitCount == 6'd1) ? END_BIT : crc[crcIdx];
      default: nextBit = END_BIT;
    endcase
  end

  always_comb begin
    crcClear   = 1'b0;
    crcAdvance = 1'b0;
    crcData    = START_BIT;
    if (acceptNow) begin
      crcClear   = 1'b1;
      crcAdvance = 1'b1;
    end else if (iEnable && (state == BODY) && (bitCount != 6'd8)) begin
      crcAdvance = 1'b1;
      crcData    = bodyShift[38];
    end
  end

  crc7_serial uCrc (
    .iClock_SD (iClock_SD),
    .iReset    (iReset),
    .iClear    (crcClear),
    .iAdvance  (crcAdvance),
    .iData     (crcData),
    .oCrc      (crc)
  );

  always_ff @(posedge iClock_SD or negedge iReset) begin
    if (!iReset) begin
      state         <= IDLE;
      bitCount      <= '0;
      bodyShift     <= '0;
      txAccum       <= '0;
      oSerial       <= 1'b1;
      oOutputEnable <= 1'b0;
      oBusy         <= 1'b0;
      oComplete     <= 1'b0;
      oFrame        <= '0;
    end else if (!iEnable) begin
      oComplete <= 1'b0;
    end else if (acceptNow) begin
      state         <= BODY;
      bitCount      <= 6'd47;
      bodyShift     <= {TX_BIT_HOST, iIndex, iArgument};
      txAccum       <= {{(FRAME_WIDTH-1){1'b0}}, START_BIT};
      oSerial       <= START_BIT;
      oOutputEnable <= 1'b1;
      oBusy         <= 1'b1;
      oComplete     <= 1'b0;
    end else begin
      case (state)
        BODY, CRC: begin
          oSerial  <= nextBit;
          txAccum  <= {txAccum[FRAME_WIDTH-2:0], nextBit};
          bitCount <= bitCount - 6'd1;
          if (state == BODY) begin
            bodyShift <= {bodyShift[37:0], 1'b0};
            if (bitCount == 6'd8) state <= CRC;
          end else if (bitCount == 6'd1) begin
            state <= ENDB;
          end
        end
        ENDB: begin
          state         <= DONE;
          oSerial       <= 1'b1;
          oOutputEnable <= 1'b0;
          oComplete     <= 1'b1;
          oFrame        <= txAccum;
        end
        DONE: begin
          // A freeze in DONE swallowed the pulse; show it again before leaving.
          if (!oComplete) begin
            oComplete <= 1'b1;
          end else begin
            state     <= IDLE;
            oBusy     <= 1'b0;
            oComplete <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_serializer.sv
// Directed bench for sd_cmd_serializer: position-based reference model compared
// every cycle, plus literal frame, timing and loopback expectations.
module tb_sd_cmd_serializer;

  logic        iClock_SD = 1'b0;
  logic        iReset;
  logic        iEnable;
  logic        iStart;
  logic [5:0]  iIndex;
  logic [31:0] iArgument;
  logic        oSerial;
  logic        oOutputEnable;
  logic        oBusy;
  logic        oComplete;
  logic [47:0] oFrame;

  int checks = 0;
  int errors = 0;

  sd_cmd_serializer dut (
    .iClock_SD     (iClock_SD),
    .iReset        (iReset),
    .iEnable       (iEnable),
    .iStart        (iStart),
    .iIndex        (iIndex),
    .iArgument     (iArgument),
    .oSerial       (oSerial),
    .oOutputEnable (oOutputEnable),
    .oBusy         (oBusy),
    .oComplete     (oComplete),
    .oFrame        (oFrame)
  );

  initial forever #5 iClock_SD = ~iClock_SD;

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] buildFrame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] body;
    body = {1'b0, 1'b1, idx, arg};
    return {body, crc7(body), 1'b1};
  endfunction

  // Model: k = enabled edges since accept (-1 when idle); 48 = completion slot.
  int          k      = -1;
  logic [47:0] mCur   = '0;
  logic [47:0] mFrame = '0;
  logic        mComp  = 1'b0;
  logic        lastAdv = 1'b0;
  logic [47:0] lb     = '0;

  always @(posedge iClock_SD or negedge iReset) begin
    if (!iReset) begin
      k = -1; mComp = 1'b0; mFrame = '0; lastAdv = 1'b0;
    end else begin
      lastAdv = iEnable;
      if (!iEnable) begin
        mComp = 1'b0;
      end else if (k < 0 || (k == 48 && mComp)) begin
        mComp = 1'b0;
        if (iStart) begin
          k = 0;
          mCur = buildFrame(iIndex, iArgument);
        end else begin
          k = -1;
        end
      end else if (k == 48) begin
        mComp = 1'b1;
      end else begin
        k++;
        if (k == 48) begin
          mComp = 1'b1;
          mFrame = mCur;
        end
      end
    end
  end

  always @(negedge iClock_SD) begin
    logic expSer, expOe;
    expOe  = (k >= 0) && (k < 48);
    expSer = expOe ? mCur[47 - k] : 1'b1;
    check("serial",   {47'b0, oSerial},       {47'b0, expSer});
    check("oe",       {47'b0, oOutputEnable}, {47'b0, expOe});
    check("busy",     {47'b0, oBusy},         {47'b0, (k >= 0)});
    check("complete", {47'b0, oComplete},     {47'b0, mComp});
    check("frame",    oFrame,                 mFrame);
    // Loopback receiver clocked by the line, enabled by oOutputEnable.
    if (iReset && lastAdv && oOutputEnable) lb = {lb[46:0], oSerial};
  end

  task automatic tick();
    @(negedge iClock_SD);
    #1;
  endtask

  task automatic waitComplete(output int n);
    n = 0;
    while (!oComplete && n < 200) begin
      tick();
      n++;
    end
    if (!oComplete) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for oComplete got %0d cycles want 48", n);
    end
  endtask

  task automatic startFrame(input logic [5:0] idx, input logic [31:0] arg);
    iStart = 1'b1; iIndex = idx; iArgument = arg;
    tick();
    iStart = 1'b0;
    iIndex = 6'($urandom);
    iArgument = $urandom;
  endtask

  task automatic frameDone(input string name, input logic [47:0] lit, input int n, input int expN);
    check({name, "_latency"},  n, expN);
    check({name, "_oFrame"},   oFrame, lit);
    check({name, "_loopback"}, lb, lit);
    check({name, "_model"},    mFrame, lit);
  endtask

  initial begin
    int n, m;
    logic held;
    iReset = 1'b0; iEnable = 1'b1; iStart = 1'b0; iIndex = '0; iArgument = '0;
    tick(); tick();
    check("rst_serial",   {47'b0, oSerial},       48'd1);
    check("rst_oe",       {47'b0, oOutputEnable}, 48'd0);
    check("rst_busy",     {47'b0, oBusy},         48'd0);
    check("rst_complete", {47'b0, oComplete},     48'd0);
    check("rst_frame",    oFrame,                 48'd0);
    iReset = 1'b1;
    tick(); tick();

    startFrame(6'd0, 32'h0);
    waitComplete(n);
    frameDone("cmd0", 48'h400000000095, n, 48);
    tick(); tick();

    startFrame(6'd8, 32'h000001AA);
    waitComplete(n);
    frameDone("cmd8", 48'h48000001AA87, n, 48);
    tick(); tick();

    // Back-to-back with iStart held high.
    iStart = 1'b1; iIndex = 6'd17; iArgument = 32'h0;
    tick();
    waitComplete(n);
    frameDone("cmd17", 48'h510000000055, n, 48);
    iIndex = 6'd55;
    tick();
    check("b2b_busy_at_E49", {47'b0, oBusy},   48'd1);
    check("b2b_start_bit",   {47'b0, oSerial}, 48'd0);
    iStart = 1'b0; iIndex = 6'($urandom); iArgument = $urandom;
    waitComplete(n);
    frameDone("cmd55", 48'h770000000065, n, 48);
    tick(); tick();

    // Five frozen cycles starting at E20.
    startFrame(6'd8, 32'h000001AA);
    repeat (19) tick();
    iEnable = 1'b0;
    held = oSerial;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("frozen_serial", {47'b0, oSerial}, {47'b0, held});
    end
    iEnable = 1'b1;
    waitComplete(m);
    frameDone("cmd8_frozen", 48'h48000001AA87, 24 + m, 53);
    tick(); tick();

    // Reset in the middle of a frame.
    startFrame(6'd8, 32'h000001AA);
    repeat (29) tick();
    @(posedge iClock_SD);
    #2 iReset = 1'b0;
    #1;
    check("abort_serial", {47'b0, oSerial},       48'd1);
    check("abort_oe",     {47'b0, oOutputEnable}, 48'd0);
    check("abort_busy",   {47'b0, oBusy},         48'd0);
    repeat (3) tick();
    check("abort_no_complete", {47'b0, oComplete}, 48'd0);
    iReset = 1'b1;
    tick(); tick();
    startFrame(6'd0, 32'h0);
    waitComplete(n);
    frameDone("cmd0_after_reset", 48'h400000000095, n, 48);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
